// File: rtl/bcd_score_acc.sv
// ---------------------------------------------------------------------------
// bcd_score_acc
//   BCD score accumulator. Each judged hit (grade + signed deviation) is turned
//   into a 3-digit BCD point value. The value is then added to the running
//   score one BCD digit per clock, least significant digit first. The block
//   also keeps the hit combo, the max combo and a sticky saturation flag.
//
// Handshake: cal is a single-cycle request. It is sampled only while the FSM
//   is IDLE (busy=0); a cal seen in any other state is dropped, not queued.
//   clr has priority over cal. Every accepted hit ends with exactly one
//   one-cycle done pulse, unless clr or rst aborts it first. score, last_pts,
//   combo, max_combo and sat are all valid from the cycle in which done is high.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   clr        in   synchronous clear of score/combo/flags, active-high
//   cal        in   request to score one hit
//   result     in   [1:0] grade 0=AC 1=perfect 2=good 3=miss; [2] ignored
//   dev        in   signed deviation, sampled together with cal
//   busy       out  accumulation in progress
//   done       out  one-cycle pulse, new score valid
//   score      out  running BCD score (DIGITS digits)
//   last_pts   out  BCD points of the last completed hit
//   combo      out  current BCD combo
//   max_combo  out  highest combo since reset/clr
//   sat        out  sticky, score saturated at all-9s
//   dbg_state  out  FSM state (0=IDLE 1=LOAD 2=ADD)
// ---------------------------------------------------------------------------
module bcd_score_acc #(
  parameter int DIGITS   = 8,
  parameter int CDIGITS  = 3,
  parameter int DEV_W    = 16,
  parameter int AC_PTS   = 100,
  parameter int PERF_PTS = 99,
  parameter int GOOD_PTS = 89,
  parameter int PEN_MAX  = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   cal,
  input  logic [2:0]             result,
  input  logic [DEV_W-1:0]       dev,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGITS-1:0]    score,
  output logic [11:0]            last_pts,
  output logic [4*CDIGITS-1:0]   combo,
  output logic [4*CDIGITS-1:0]   max_combo,
  output logic                   sat,
  output logic [1:0]             dbg_state
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = 4 * CDIGITS;
  localparam int IW = $clog2(DIGITS + 1);

  localparam logic [SW-1:0]    S_ALL9  = {DIGITS{4'h9}};
  localparam logic [CW-1:0]    C_ALL9  = {CDIGITS{4'h9}};
  localparam logic [DEV_W-1:0] PEN_LIM = DEV_W'(PEN_MAX);
  localparam logic [IW-1:0]    IDX_COMMIT = IW'(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ADD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_grade;
  logic [DEV_W-1:0] r_dev;
  logic [11:0]      r_pts;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [SW-1:0]    r_shadow;
  logic [SW-1:0]    r_score;
  logic [11:0]      r_last_pts;
  logic [CW-1:0]    r_combo;
  logic [CW-1:0]    r_max;
  logic             r_sat;
  logic             r_done;

  // 10-bit binary (<=999) to 3-digit BCD, shift-and-add-3.
  function automatic logic [11:0] bin2bcd(input logic [9:0] b);
    logic [11:0] v;
    v = '0;
    for (int i = 9; i >= 0; i--) begin
      for (int j = 0; j < 3; j++) begin
        if (v[4*j +: 4] >= 4'd5) v[4*j +: 4] = v[4*j +: 4] + 4'd3;
      end
      v = {v[10:0], b[i]};
    end
    return v;
  endfunction

  // BCD increment that sticks at all-9s.
  function automatic logic [CW-1:0] bcd_inc_sat(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    if (v != C_ALL9) begin
      for (int j = 0; j < CDIGITS; j++) begin
        if (c) begin
          if (r[4*j +: 4] == 4'd9) begin
            r[4*j +: 4] = 4'd0;
          end else begin
            r[4*j +: 4] = r[4*j +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // ---- point computation (used in LOAD) ----
  // The two's-complement negate of the most negative value yields
  // 2^(DEV_W-1), which is exact when read as unsigned DEV_W bits.
  logic [DEV_W-1:0] w_mag;
  logic [9:0]       w_pen;
  logic [9:0]       w_base;
  logic [9:0]       w_bin;
  logic [11:0]      w_pts_bcd;

  always_comb begin
    w_mag  = r_dev[DEV_W-1] ? (~r_dev + 1'b1) : r_dev;
    w_pen  = (w_mag > PEN_LIM) ? 10'(PEN_MAX) : 10'(w_mag);
    w_base = (r_grade == 2'd1) ? 10'(PERF_PTS) : 10'(GOOD_PTS);
    w_bin  = '0;
    case (r_grade)
      2'd0:    w_bin = 10'(AC_PTS);
      2'd3:    w_bin = '0;
      default: w_bin = (w_base > w_pen) ? (w_base - w_pen) : 10'd0;
    endcase
    w_pts_bcd = bin2bcd(w_bin);
  end

  // ---- digit adder (used in ADD) ----
  // ADD runs with r_idx = 0..DIGITS-1 for the digits, then one more cycle
  // with r_idx = DIGITS to commit the shadow result.
  logic          w_commit;
  logic [IW-1:0] w_di;
  logic [SW-1:0] w_pts_ext;
  logic [3:0]    w_sdig;
  logic [3:0]    w_pdig;
  logic [4:0]    w_sum;
  logic [3:0]    w_dig;
  logic          w_cout;
  logic [CW-1:0] w_combo_new;

  always_comb begin
    w_commit  = (r_idx == IDX_COMMIT);
    w_di      = w_commit ? '0 : r_idx;
    w_pts_ext = SW'(r_pts);
    w_sdig    = r_score[w_di*4 +: 4];
    w_pdig    = w_pts_ext[w_di*4 +: 4];
    w_sum     = {1'b0, w_sdig} + {1'b0, w_pdig} + {4'b0, r_carry};
    w_cout    = (w_sum > 5'd9);
    w_dig     = w_cout ? 4'(w_sum - 5'd10) : w_sum[3:0];
    w_combo_new = (r_grade == 2'd3) ? '0 : bcd_inc_sat(r_combo);
  end

  // ---- FSM and all state ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grade    <= '0;
      r_dev      <= '0;
      r_pts      <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_shadow   <= '0;
      r_score    <= '0;
      r_last_pts <= '0;
      r_combo    <= '0;
      r_max      <= '0;
      r_sat      <= 1'b0;
      r_done     <= 1'b0;
    end else if (clr) begin
      // Aborts any in-flight add without a done pulse.
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_score    <= '0;
      r_last_pts <= '0;
      r_combo    <= '0;
      r_max      <= '0;
      r_sat      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cal) begin
            r_grade <= result[1:0];
            r_dev   <= dev;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_pts    <= w_pts_bcd;
          r_idx    <= '0;
          r_carry  <= 1'b0;
          r_shadow <= r_score;
          r_state  <= S_ADD;
        end
        S_ADD: begin
          if (w_commit) begin
            // r_carry now holds the carry out of the most significant digit.
            if (r_carry || r_sat) begin
              r_score <= S_ALL9;
              r_sat   <= 1'b1;
            end else begin
              r_score <= r_shadow;
            end
            r_last_pts <= r_pts;
            r_combo    <= w_combo_new;
            if (w_combo_new > r_max) r_max <= w_combo_new;
            r_done  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_shadow[w_di*4 +: 4] <= w_dig;
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign score     = r_score;
  assign last_pts  = r_last_pts;
  assign combo     = r_combo;
  assign max_combo = r_max;
  assign sat       = r_sat;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_score_acc.sv
// ---------------------------------------------------------------------------
// tb_bcd_score_acc
//   Bench for bcd_score_acc. The main instance uses DIGITS=8 and a reference
//   model whose expected results go into a queue when each hit is driven.
//   The queue is popped when done pulses. A second instance with DIGITS=3
//   covers the saturation path.
// ---------------------------------------------------------------------------
module tb_bcd_score_acc;

  localparam int D8 = 8;
  localparam int D3 = 3;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              cal;
  logic              clr3;
  logic              cal3;
  logic [2:0]        result;
  logic signed [15:0] dev;

  logic              busy, done, sat;
  logic [31:0]       score;
  logic [11:0]       last_pts, combo, max_combo;
  logic [1:0]        dbg_state;

  logic              busy3, done3, sat3;
  logic [11:0]       score3;
  logic [11:0]       last_pts3, combo3, max_combo3;
  logic [1:0]        dbg_state3;

  int n_checks = 0;
  int n_fail   = 0;

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_score_acc #(.DIGITS(D8)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .cal(cal), .result(result), .dev(dev),
    .busy(busy), .done(done), .score(score), .last_pts(last_pts),
    .combo(combo), .max_combo(max_combo), .sat(sat), .dbg_state(dbg_state)
  );

  bcd_score_acc #(.DIGITS(D3)) u_dut3 (
    .clk(clk), .rst(rst), .clr(clr3), .cal(cal3), .result(result), .dev(dev),
    .busy(busy3), .done(done3), .score(score3), .last_pts(last_pts3),
    .combo(combo3), .max_combo(max_combo3), .sat(sat3), .dbg_state(dbg_state3)
  );

  // ---- checking ----
  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  longint m_score;
  int     m_combo, m_max;
  bit     m_sat;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pts_q[$];
  logic [31:0] exp_combo_q[$];
  logic [31:0] exp_max_q[$];
  logic [31:0] exp_sat_q[$];

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r;
    longint      t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int pts_of(input int g, input int d);
    int mag, pen, p;
    if (g == 0) return 100;
    if (g == 3) return 0;
    mag = (d < 0) ? -d : d;
    pen = (mag > 63) ? 63 : mag;
    p   = ((g == 1) ? 99 : 89) - pen;
    return (p < 0) ? 0 : p;
  endfunction

  task automatic model_clear();
    m_score = 0; m_combo = 0; m_max = 0; m_sat = 1'b0;
  endtask

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 32'(done), 32'd0);
      end else begin
        check_val("score",     score,            exp_q.pop_front());
        check_val("last_pts",  32'(last_pts),    exp_pts_q.pop_front());
        check_val("combo",     32'(combo),       exp_combo_q.pop_front());
        check_val("max_combo", 32'(max_combo),   exp_max_q.pop_front());
        check_val("sat",       32'(sat),         exp_sat_q.pop_front());
        check_val("busy_at_done", 32'(busy),     32'd0);
      end
    end
  end

  // ---- driver tasks ----
  // Drive one hit, push its expectation, wait for done and check latency.
  // With poke=1 a second cal is pulsed mid-add; it must be ignored.
  task automatic send_hit(input int g, input int d, input bit poke);
    int  p, lat;
    bit  r2;
    r2 = 1'($urandom_range(0, 1));
    @(negedge clk);
    cal    = 1'b1;
    result = {r2, 2'(g)};
    dev    = 16'(d);
    p = pts_of(g, d);
    m_score = m_score + p;
    if (m_score > 64'd99999999) begin
      m_score = 99999999;
      m_sat   = 1'b1;
    end
    m_combo = (g == 3) ? 0 : ((m_combo < 999) ? m_combo + 1 : 999);
    if (m_combo > m_max) m_max = m_combo;
    exp_q.push_back(to_bcd(m_score));
    exp_pts_q.push_back(to_bcd(p));
    exp_combo_q.push_back(to_bcd(m_combo));
    exp_max_q.push_back(to_bcd(m_max));
    exp_sat_q.push_back(32'(m_sat));
    @(posedge clk);
    #1;
    cal = 1'b0;
    check_val("busy_after_cal", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 3) begin
        cal    = 1'b1;
        result = 3'd0;
      end
      @(posedge clk);
      #1;
      cal = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    check_val("latency", 32'(lat), 32'(D8 + 2));
  endtask

  // Start a hit that will be aborted; nothing is expected from it.
  task automatic start_raw(input int g, input int d);
    @(negedge clk);
    cal    = 1'b1;
    result = 3'(g);
    dev    = 16'(d);
    @(posedge clk);
    #1;
    cal = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
    check_val("clr_score", score, 32'd0);
    check_val("clr_sat",   32'(sat), 32'd0);
    check_val("clr_combo", 32'(combo), 32'd0);
    check_val("clr_max",   32'(max_combo), 32'd0);
    check_val("clr_busy",  32'(busy), 32'd0);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 32'd0);
  endtask

  task automatic send3(input int expect_bcd, input bit expect_sat);
    int lat;
    @(negedge clk);
    cal3   = 1'b1;
    result = 3'd0;
    dev    = '0;
    @(posedge clk);
    #1;
    cal3 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        lat = k;
        break;
      end
    end
    check_val("d3_latency", 32'(lat), 32'(D3 + 2));
    check_val("d3_score",   32'(score3), 32'(expect_bcd));
    check_val("d3_sat",     32'(sat3), 32'(expect_sat));
  endtask

  // ---- main sequence ----
  initial begin
    rst = 1'b0; clr = 1'b0; cal = 1'b0; clr3 = 1'b0; cal3 = 1'b0;
    result = '0; dev = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_score", score, 32'd0);
    check_val("rst_busy",  32'(busy), 32'd0);
    check_val("rst_done",  32'(done), 32'd0);
    check_val("rst_last",  32'(last_pts), 32'd0);
    check_val("rst_combo", 32'(combo), 32'd0);
    check_val("rst_sat",   32'(sat), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single AC hit: 100 points.
    send_hit(0, 0, 1'b0);

    // Async reset in the middle of an add.
    start_raw(1, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_score", score, 32'd0);
    check_val("arst_busy",  32'(busy), 32'd0);
    check_val("arst_last",  32'(last_pts), 32'd0);
    check_val("arst_combo", 32'(max_combo), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_val("arst_idle_busy", 32'(busy), 32'd0);

    // 94 then 26 points from zero -> 120.
    send_hit(1, -5, 1'b0);
    send_hit(2, 70, 1'b0);
    check_val("sum_120", score, 32'h0000_0120);

    // Combo sequence 1,2,3,0.
    do_clr();
    send_hit(0, int'($urandom_range(0, 200)) - 100, 1'b0);
    send_hit(1, int'($urandom_range(0, 200)) - 100, 1'b0);
    send_hit(2, int'($urandom_range(0, 200)) - 100, 1'b0);
    send_hit(3, int'($urandom_range(0, 200)) - 100, 1'b0);
    check_val("miss_combo", 32'(combo), 32'd0);
    check_val("miss_max",   32'(max_combo), 32'h3);
    check_val("miss_last",  32'(last_pts), 32'd0);
    check_val("miss_score", score, to_bcd(m_score));

    // cal while busy is dropped.
    send_hit(1, 10, 1'b1);
    watch_no_done("busy_cal_dropped", 15);

    // clr two cycles into ADD: no done, everything zero.
    start_raw(0, 0);
    repeat (3) @(posedge clk);
    do_clr();
    watch_no_done("clr_abort_no_done", 15);

    // cal together with clr: clr wins.
    @(negedge clk);
    clr = 1'b1; cal = 1'b1; result = 3'd0;
    @(posedge clk);
    #1;
    clr = 1'b0; cal = 1'b0;
    check_val("clr_beats_cal", 32'(busy), 32'd0);
    watch_no_done("clr_cal_no_done", 12);

    // Most negative deviation clamps to the maximum penalty: 36 points.
    send_hit(1, -32768, 1'b0);
    check_val("min_dev_pts", 32'(last_pts), 32'h036);

    // Random hits through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      send_hit(int'($urandom_range(0, 3)), int'($urandom_range(0, 300)) - 150, 1'b0);
    end

    // Saturation on the 3-digit instance.
    for (int i = 1; i <= 9; i++) send3(i * 256, 1'b0);
    send3(12'h999, 1'b1);
    send3(12'h999, 1'b1);
    @(negedge clk);
    clr3 = 1'b1;
    @(posedge clk);
    #1;
    clr3 = 1'b0;
    check_val("d3_clr_score", 32'(score3), 32'd0);
    check_val("d3_clr_sat",   32'(sat3), 32'd0);

    repeat (3) @(posedge clk);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
